piso: RTL and testbench



---
 rtl/piso.sv | 57 +++++
 tb/tb_piso.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/piso.sv
// Parameterised parallel-in, serial-out shift register.
// A load captures an n-bit word; it then leaves one bit per clock on serial_out.
module piso #(
    parameter int   n         = 4,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic FILL      = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [n-1:0] parallel_in,
    output logic         serial_out,
    output logic         busy,
    output logic         last_bit
);

    localparam int CW = $clog2(n + 1);

    logic [n-1:0]  shift_reg;
    logic [n-1:0]  shift_next;
    logic [CW-1:0] count;

    // A one-bit register has no bits to keep, so it simply takes the fill value.
    generate
        if (n == 1) begin : g_single
            assign shift_next = FILL;
        end else if (MSB_FIRST) begin : g_msb
            assign shift_next = {shift_reg[n-2:0], FILL};
        end else begin : g_lsb
            assign shift_next = {FILL, shift_reg[n-1:1]};
        end
    endgenerate

    // Data and remaining-bit counter; priority is reset, then load, then shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            count     <= '0;
        end else if (load) begin
            shift_reg <= parallel_in;
            count     <= CW'(n);
        end else begin
            shift_reg <= shift_next;
            if (count != '0) begin
                count <= count - CW'(1);
            end else begin
                count <= count;
            end
        end
    end

    // All outputs decode registered state only.
    assign serial_out = MSB_FIRST ? shift_reg[n-1] : shift_reg[0];
    assign busy       = (count != '0);
    assign last_bit   = (count == CW'(1));

endmodule

// File: tb/tb_piso.sv
// Scoreboard bench for piso: stimulus queues expected serial bits, per-DUT monitors
// pop and compare them whenever the DUT reports busy.
module tb_piso;

    logic       clk = 1'b0;
    logic       rst;
    logic       load4, load_l, load8;
    logic [3:0] pin4, pin_l;
    logic [7:0] pin8;
    logic       so4, busy4, last4;
    logic       so_l, busy_l, last_l;
    logic       so8, busy8, last8;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Each entry is {expected serial bit, expected last_bit}.
    logic [1:0] q4[$];
    logic [1:0] ql[$];
    logic [1:0] q8[$];

    logic [3:0] s2_exp [5] = '{4'b1011, 4'b0110, 4'b1100, 4'b1000, 4'b0000};

    always #5 clk = ~clk;

    piso #(.n(4), .MSB_FIRST(1'b1), .FILL(1'b0)) u4 (
        .clk(clk), .rst(rst), .load(load4), .parallel_in(pin4),
        .serial_out(so4), .busy(busy4), .last_bit(last4)
    );

    piso #(.n(4), .MSB_FIRST(1'b0), .FILL(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load(load_l), .parallel_in(pin_l),
        .serial_out(so_l), .busy(busy_l), .last_bit(last_l)
    );

    piso #(.n(8), .MSB_FIRST(1'b1), .FILL(1'b0)) u8 (
        .clk(clk), .rst(rst), .load(load8), .parallel_in(pin8),
        .serial_out(so8), .busy(busy8), .last_bit(last8)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Queue the first 'keep' bits of word w in shift order for DUT 'which'.
    task automatic push_word(input int which, input logic [7:0] w, input int nbits,
                             input int keep, input bit msb);
        logic [1:0] e;
        for (int k = 0; k < keep; k++) begin
            e[1] = msb ? w[nbits-1-k] : w[k];
            e[0] = (k == nbits - 1);
            if (which == 0) q4.push_back(e);
            else if (which == 1) ql.push_back(e);
            else q8.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the n=4 MSB-first instance.
    always @(negedge clk) begin
        logic [1:0] e;
        if (mon_en) begin
            if (busy4) begin
                if (q4.size() == 0) begin
                    chk("m4_unexpected_busy", {7'd0, busy4}, 8'd0);
                end else begin
                    e = q4.pop_front();
                    chk("m4_bit", {7'd0, so4}, {7'd0, e[1]});
                    chk("m4_last", {7'd0, last4}, {7'd0, e[0]});
                end
            end else begin
                chk("m4_idle", {6'd0, so4, last4}, 8'd0);
            end
        end
    end

    // Monitor for the LSB-first instance.
    always @(negedge clk) begin
        logic [1:0] e;
        if (mon_en) begin
            if (busy_l) begin
                if (ql.size() == 0) begin
                    chk("ml_unexpected_busy", {7'd0, busy_l}, 8'd0);
                end else begin
                    e = ql.pop_front();
                    chk("ml_bit", {7'd0, so_l}, {7'd0, e[1]});
                    chk("ml_last", {7'd0, last_l}, {7'd0, e[0]});
                end
            end else begin
                chk("ml_idle", {6'd0, so_l, last_l}, 8'd0);
            end
        end
    end

    // Monitor for the n=8 instance.
    always @(negedge clk) begin
        logic [1:0] e;
        if (mon_en) begin
            if (busy8) begin
                if (q8.size() == 0) begin
                    chk("m8_unexpected_busy", {7'd0, busy8}, 8'd0);
                end else begin
                    e = q8.pop_front();
                    chk("m8_bit", {7'd0, so8}, {7'd0, e[1]});
                    chk("m8_last", {7'd0, last8}, {7'd0, e[0]});
                end
            end else begin
                chk("m8_idle", {6'd0, so8, last8}, 8'd0);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        load4  = 1'b1;
        load_l = 1'b1;
        load8  = 1'b1;
        pin4   = 4'b1111;
        pin_l  = 4'b1111;
        pin8   = 8'hFF;

        // Reset beats a coincident load.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_shift_reg", {4'd0, u4.shift_reg}, 8'd0);
            chk("rst_serial_out", {7'd0, so4}, 8'd0);
            chk("rst_busy", {7'd0, busy4}, 8'd0);
            chk("rst_last_bit", {7'd0, last4}, 8'd0);
        end
        rst    = 1'b0;
        load4  = 1'b0;
        load_l = 1'b0;
        load8  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single word 1011, MSB first, with register contents tracked.
        push_word(0, 8'h0B, 4, 4, 1'b1);
        pin4  = 4'b1011;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("s2_shift_reg", {4'd0, u4.shift_reg}, {4'd0, s2_exp[k]});
            tick();
        end
        tick();

        // Next word 1100.
        push_word(0, 8'h0C, 4, 4, 1'b1);
        pin4  = 4'b1100;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        repeat (6) tick();

        // Load mid-word: two bits of 1011 then all of 0101.
        push_word(0, 8'h0B, 4, 2, 1'b1);
        pin4  = 4'b1011;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        tick();
        push_word(0, 8'h05, 4, 4, 1'b1);
        pin4  = 4'b0101;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        chk("s4_count_reload", {5'd0, u4.count}, 8'd4);
        repeat (6) tick();

        // Reset mid-word: two bits of 1111, then reset.
        push_word(0, 8'h0F, 4, 2, 1'b1);
        pin4  = 4'b1111;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_serial_out", {7'd0, so4}, 8'd0);
        chk("s5_busy", {7'd0, busy4}, 8'd0);
        repeat (4) tick();

        // Parameter variants: LSB-first 1011 and n=8 A5.
        push_word(1, 8'h0B, 4, 4, 1'b0);
        push_word(2, 8'hA5, 8, 8, 1'b1);
        pin_l  = 4'b1011;
        pin8   = 8'hA5;
        load_l = 1'b1;
        load8  = 1'b1;
        tick();
        load_l = 1'b0;
        load8  = 1'b0;
        repeat (10) tick();

        chk("q4_drained", 8'(q4.size()), 8'd0);
        chk("ql_drained", 8'(ql.size()), 8'd0);
        chk("q8_drained", 8'(q8.size()), 8'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
